tensor_core_sequencer: RTL and testbench
========================================

TENSOR_CORE_SEQUENCER -- requirements
Module: tensor_core_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, signed element width.
REQ-002 SHALL have parameter ACC_WIDTH, default 20, signed MAC accumulator width.
REQ-003 SHALL have one clock `clock_in`, input, 1, with all state updated on its rising edge.
REQ-004 SHALL have reset `reset_in`, input, 1, asynchronous and active-high.
REQ-005 SHALL have `current_tensor_core_instruction`, input, 16, instruction/data word from the memory controller, sampled every clock.
REQ-006 SHALL have `tensor_core_controller_output`, output, DATA_WIDTH, signed burst-read data.
REQ-007 SHALL have `output_valid`, output, 1, high while `tensor_core_controller_output` carries a burst-read byte.
REQ-008 SHALL have `busy`, output, 1, high while a burst or operate sequence is in progress.

Function
REQ-009 SHALL hold a 27-byte signed register space: A = addr 0..8, B = addr 9..17, C = addr 18..26, all row-major 3x3.
REQ-010 SHALL use states IDLE, BURST_WR, BURST_RD, OP_MAC, OP_ELEM.
REQ-011 In IDLE, SHALL decode the word's opcode in bits [1:0]: 00 NOP, 01 OPERATE, 10 BURST, 11 RESET.
REQ-012 BURST header fields SHALL be: [3:2] select (00 read, 01 write, 10 write-then-read, 11 NOP); [8:4] start address; [13:9] count.
REQ-013 Count 0 or start address >26 SHALL make the header a NOP.
REQ-014 BURST_WR SHALL consume the next `count` words, each one cycle.
  - Each word writes [15:8] to addr p and [7:0] to addr p+1.
  - p starts at the start address and advances by 2 per word.
  - Addresses wrap 26->0.
REQ-015 BURST_RD SHALL, for `count` cycles starting the cycle after entry, drive the byte at addr p with `output_valid`=1; p advances by 1 and wraps 26->0.
  - Incoming words during BURST_RD SHALL be ignored unless the opcode is RESET.
REQ-016 Select 10 SHALL run BURST_WR, then BURST_RD from the same start address with the same count, with no idle cycle between them.
REQ-017 OPERATE bits [3:2] SHALL select the operation: 00 C=A*B (OP_MAC), 01 C=A+B (OP_ELEM), 10 C=transpose(A) (OP_ELEM), 11 NOP.
REQ-018 OP_MAC SHALL perform one signed multiply-accumulate per cycle in ACC_WIDTH bits.
  - Order: i, j, then k innermost.
  - C[i][j] is written, saturated to [-128,127], on the cycle its k=2 MAC completes.
  - The accumulator clears for the next element.
  - Total: 27 cycles.
REQ-019 OP_ELEM SHALL write one C element per cycle, 9 cycles, in row-major order. Add results SHALL saturate to [-128,127].
REQ-020 `busy` SHALL rise the cycle after a non-NOP BURST or OPERATE header is accepted, and fall the cycle after the last write or read beat.
REQ-021 In any state, an incoming word with opcode 11 (RESET) SHALL have the same effect as `reset_in`, applied synchronously at the next edge.
  - Exception: in BURST_WR, words are data and SHALL NOT be decoded.
REQ-022 `tensor_core_controller_output` SHALL be 0 whenever `output_valid` is 0.

Reset
REQ-023 `reset_in` high SHALL, asynchronously:
  - force IDLE;
  - clear all 27 bytes, the accumulator and the address/count/step counters;
  - drive `busy`=0, `output_valid`=0 and `tensor_core_controller_output`=0.
REQ-024 Reset asserted mid-sequence SHALL abort the sequence with no further writes. After release, the first word SHALL be decoded as an IDLE instruction.

Verification
REQ-025 Bench: burst write header start 0, count 9, with words loading A = 1..9 and B = identity, then burst read start 0, count 18 -> bytes 1..9,1,0,0,0,1,0,0,0,1, `output_valid` high for exactly 18 cycles.
REQ-026 Bench: with the A and B above, OPERATE 00 -> `busy` high for 27 cycles; then read addr 18..26 -> 1..9.
REQ-027 Bench: A all 127, B all 127, OPERATE 00 -> all C = 127 (saturated). A all -128, B all 127, OPERATE 01 -> all C = -1.
REQ-028 Bench: burst write start 26, count 1, word 0x0506 -> addr 26 = 5, addr 0 = 6 (wrap).
REQ-029 Bench: assert `reset_in` at cycle 10 of a matmul -> `busy`=0 immediately; all bytes read back 0; next OPERATE executes normally.
REQ-030 Bench: RESET opcode word during BURST_RD -> output stops the next cycle and the state returns to IDLE. Word 0x0003 sent as data in BURST_WR -> addr p = 0x00, addr p+1 = 0x03, no reset.

Source files
------------

// File: rtl/tensor_core_sequencer_if.sv
// Memory-controller link of the tensor core sequencer: instruction word in, burst data and status out.
// The controller side drives the instruction; the sequencer side drives data, valid and busy.
interface tensor_core_sequencer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [15:0]                  current_tensor_core_instruction;
    logic signed [DATA_WIDTH-1:0] tensor_core_controller_output;
    logic                         output_valid;
    logic                         busy;

    modport master (
        output current_tensor_core_instruction,
        input  tensor_core_controller_output,
        input  output_valid,
        input  busy
    );

    modport slave (
        input  current_tensor_core_instruction,
        output tensor_core_controller_output,
        output output_valid,
        output busy
    );
endinterface

// File: rtl/tensor_core_sequencer.sv
// 3x3 tensor sequencer: burst read/write of a 27-byte A/B/C space plus C=A*B, A+B, transpose(A).
// Read data valid the cycle after the header; MAC 27 cycles, elementwise 9; no backpressure, a word is taken every cycle.
module tensor_core_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 20
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    tensor_core_sequencer_if.slave bus
);
    localparam int NUM_BYTES = 27;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-(64'sd1 <<< (DATA_WIDTH - 1)));

    typedef enum logic [2:0] {IDLE, BURST_WR, BURST_RD, OP_MAC, OP_ELEM} state_t;

    state_t state, state_nxt;

    logic signed [DATA_WIDTH-1:0] mem [NUM_BYTES];
    logic signed [ACC_WIDTH-1:0]  acc;
    logic [4:0] ptr, cnt, base, len;
    logic       rd_after, elem_tr;
    logic [1:0] i, j, kk;

    logic [15:0] word;
    logic [1:0]  opcode, sel;
    logic [4:0]  hdr_start, hdr_cnt;
    logic        burst_ok, soft_reset;

    assign word      = bus.current_tensor_core_instruction;
    assign opcode    = word[1:0];
    assign sel       = word[3:2];
    assign hdr_start = word[8:4];
    assign hdr_cnt   = word[13:9];
    assign burst_ok  = (opcode == 2'b10) && (sel != 2'b11) && (hdr_cnt != 5'd0) && (hdr_start <= 5'd26);
    // Inside a write burst every word is payload, so a RESET opcode there is just data.
    assign soft_reset = (opcode == 2'b11) && (state != BURST_WR);

    logic [4:0] ptr1, ptr2, row3, mac_a, mac_b, c_idx, el_a, el_b, tr_a;
    assign ptr1  = (ptr == 5'd26) ? 5'd0 : ptr + 5'd1;
    assign ptr2  = (ptr1 == 5'd26) ? 5'd0 : ptr1 + 5'd1;
    assign row3  = 5'(i) * 5'd3;
    assign mac_a = row3 + 5'(kk);
    assign mac_b = 5'd9 + 5'(kk) * 5'd3 + 5'(j);
    assign c_idx = 5'd18 + row3 + 5'(j);
    assign el_a  = row3 + 5'(j);
    assign el_b  = 5'd9 + el_a;
    assign tr_a  = 5'(j) * 5'd3 + 5'(i);

    logic signed [ACC_WIDTH-1:0] mac_sum, add_sum;
    assign mac_sum = acc + ACC_WIDTH'(mem[mac_a]) * ACC_WIDTH'(mem[mac_b]);
    assign add_sum = ACC_WIDTH'(mem[el_a]) + ACC_WIDTH'(mem[el_b]);

    function automatic logic signed [DATA_WIDTH-1:0] saturate(input logic signed [ACC_WIDTH-1:0] v);
        if (v > SAT_MAX) return SAT_MAX[DATA_WIDTH-1:0];
        if (v < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
        return v[DATA_WIDTH-1:0];
    endfunction

    assign bus.busy                          = (state != IDLE);
    assign bus.output_valid                  = (state == BURST_RD);
    assign bus.tensor_core_controller_output = (state == BURST_RD) ? mem[ptr] : '0;

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (burst_ok)
                    state_nxt = (sel == 2'b00) ? BURST_RD : BURST_WR;
                else if (opcode == 2'b01 && sel == 2'b00)
                    state_nxt = OP_MAC;
                else if (opcode == 2'b01 && sel != 2'b11)
                    state_nxt = OP_ELEM;
            end
            BURST_WR: if (cnt == 5'd1) state_nxt = rd_after ? BURST_RD : IDLE;
            BURST_RD: if (cnt == 5'd1) state_nxt = IDLE;
            OP_MAC:   if (i == 2'd2 && j == 2'd2 && kk == 2'd2) state_nxt = IDLE;
            OP_ELEM:  if (i == 2'd2 && j == 2'd2) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
        if (soft_reset) state_nxt = IDLE;
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            for (int n = 0; n < NUM_BYTES; n++) mem[n] <= '0;
            acc <= '0; ptr <= '0; cnt <= '0; base <= '0; len <= '0;
            rd_after <= 1'b0; elem_tr <= 1'b0; i <= '0; j <= '0; kk <= '0;
        end else if (soft_reset) begin
            for (int n = 0; n < NUM_BYTES; n++) mem[n] <= '0;
            acc <= '0; ptr <= '0; cnt <= '0; base <= '0; len <= '0;
            rd_after <= 1'b0; elem_tr <= 1'b0; i <= '0; j <= '0; kk <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (burst_ok) begin
                        ptr      <= hdr_start;
                        cnt      <= hdr_cnt;
                        base     <= hdr_start;
                        len      <= hdr_cnt;
                        rd_after <= (sel == 2'b10);
                    end else if (opcode == 2'b01) begin
                        acc     <= '0;
                        i       <= '0;
                        j       <= '0;
                        kk      <= '0;
                        elem_tr <= (sel == 2'b10);
                    end
                end
                BURST_WR: begin
                    mem[ptr]  <= DATA_WIDTH'($signed(word[15:8]));
                    mem[ptr1] <= DATA_WIDTH'($signed(word[7:0]));
                    // Rewind on the last word so a chained read starts from the header address.
                    if (cnt == 5'd1) begin
                        ptr <= base;
                        cnt <= len;
                    end else begin
                        ptr <= ptr2;
                        cnt <= cnt - 5'd1;
                    end
                end
                BURST_RD: begin
                    ptr <= ptr1;
                    cnt <= cnt - 5'd1;
                end
                OP_MAC: begin
                    if (kk == 2'd2) begin
                        mem[c_idx] <= saturate(mac_sum);
                        acc        <= '0;
                        kk         <= '0;
                        if (j == 2'd2) begin
                            j <= '0;
                            i <= (i == 2'd2) ? 2'd0 : i + 2'd1;
                        end else begin
                            j <= j + 2'd1;
                        end
                    end else begin
                        acc <= mac_sum;
                        kk  <= kk + 2'd1;
                    end
                end
                OP_ELEM: begin
                    mem[c_idx] <= elem_tr ? mem[tr_a] : saturate(add_sum);
                    if (j == 2'd2) begin
                        j <= '0;
                        i <= (i == 2'd2) ? 2'd0 : i + 2'd1;
                    end else begin
                        j <= j + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tensor_core_sequencer.sv
// Directed and randomized checks of tensor_core_sequencer against an array-based model of the register space.
module tb_tensor_core_sequencer;
    localparam int DW = 8;
    localparam int AW = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tensor_core_sequencer_if #(.DATA_WIDTH(DW)) bus ();

    tensor_core_sequencer #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
        .clock_in (clk),
        .reset_in (rst),
        .bus      (bus)
    );

    int tests = 0;
    int fails = 0;
    int m [27];
    logic [15:0] wq [$];

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int s8(input int x);
        logic [7:0] b;
        b = x[7:0];
        return int'($signed(b));
    endfunction

    function automatic int sat(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    task automatic model_clear();
        for (int n = 0; n < 27; n++) m[n] = 0;
    endtask

    task automatic model_op(input int sel);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                int s = 0;
                if (sel == 0) begin
                    for (int k = 0; k < 3; k++) s += m[r*3+k] * m[9+k*3+c];
                    m[18+r*3+c] = sat(s);
                end else if (sel == 1) begin
                    m[18+r*3+c] = sat(m[r*3+c] + m[9+r*3+c]);
                end else begin
                    m[18+r*3+c] = m[c*3+r];
                end
            end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] w);
        bus.current_tensor_core_instruction = w;
        tick();
    endtask

    task automatic burst_hdr(input int sel, input int start, input int cnt);
        send(16'((cnt << 9) | (start << 4) | (sel << 2) | 2));
    endtask

    task automatic rd_check(input int start, input int n);
        int p = start;
        for (int x = 0; x < n; x++) begin
            check("rd_valid", bus.output_valid, 1);
            check("rd_busy", bus.busy, 1);
            check("rd_data", bus.tensor_core_controller_output, m[p]);
            p = (p + 1) % 27;
            tick();
        end
        check("rd_valid_end", bus.output_valid, 0);
        check("rd_data_idle", bus.tensor_core_controller_output, 0);
        check("rd_busy_end", bus.busy, 0);
    endtask

    task automatic bread(input int start, input int n);
        burst_hdr(0, start, n);
        bus.current_tensor_core_instruction = 16'h0000;
        rd_check(start, n);
    endtask

    task automatic bwrite(input int start, input bit then_read);
        int p = start;
        int n = wq.size();
        burst_hdr(then_read ? 2 : 1, start, n);
        for (int x = 0; x < n; x++) begin
            check("wr_busy", bus.busy, 1);
            check("wr_valid", bus.output_valid, 0);
            m[p] = s8(int'(wq[x][15:8]));
            m[(p + 1) % 27] = s8(int'(wq[x][7:0]));
            p = (p + 2) % 27;
            send(wq[x]);
        end
        bus.current_tensor_core_instruction = 16'h0000;
        if (then_read) rd_check(start, n);
        else           check("wr_busy_end", bus.busy, 0);
    endtask

    task automatic load_ab(input int a [9], input int b [9]);
        int by [18];
        for (int k = 0; k < 9; k++) begin
            by[k]     = a[k];
            by[9 + k] = b[k];
        end
        wq.delete();
        for (int k = 0; k < 9; k++) wq.push_back({by[2*k][7:0], by[2*k+1][7:0]});
        bwrite(0, 1'b0);
    endtask

    task automatic operate(input int sel);
        int n = 0;
        int exp_cycles = (sel == 0) ? 27 : 9;
        send(16'((sel << 2) | 1));
        bus.current_tensor_core_instruction = 16'h0000;
        while (bus.busy === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        check("op_busy_cycles", n, exp_cycles);
        model_op(sel);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a [9];
        int b [9];
        int n;
        bus.current_tensor_core_instruction = 16'h0000;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.output_valid, 0);
        check("rst_data", bus.tensor_core_controller_output, 0);
        rst = 1'b0;
        tick();

        // A = 1..9, B = identity, read back 18 bytes
        for (int k = 0; k < 9; k++) begin
            a[k] = k + 1;
            b[k] = (k % 4 == 0) ? 1 : 0;
        end
        load_ab(a, b);
        bread(0, 18);

        operate(0);
        bread(18, 9);

        // Saturating MAC and saturating add
        for (int k = 0; k < 9; k++) begin a[k] = 127; b[k] = 127; end
        load_ab(a, b);
        operate(0);
        bread(18, 9);
        for (int k = 0; k < 9; k++) a[k] = -128;
        load_ab(a, b);
        operate(1);
        bread(18, 9);

        // Transpose of a distinct-valued A
        for (int k = 0; k < 9; k++) a[k] = 10 * k - 40;
        load_ab(a, b);
        operate(2);
        bread(18, 9);

        // Write wrap 26 -> 0
        wq.delete();
        wq.push_back(16'h0506);
        bwrite(26, 1'b0);
        bread(26, 2);

        // RESET opcode as burst-write payload is plain data
        wq.delete();
        wq.push_back(16'h0003);
        bwrite(7, 1'b0);
        bread(7, 2);

        // Headers that must be ignored: count 0, start above 26, select 11
        burst_hdr(1, 5, 0);
        check("nop_cnt0_busy", bus.busy, 0);
        burst_hdr(0, 27, 3);
        check("nop_start27_busy", bus.busy, 0);
        burst_hdr(3, 0, 3);
        check("nop_sel3_busy", bus.busy, 0);
        send(16'h000D);
        check("nop_op3_busy", bus.busy, 0);
        bus.current_tensor_core_instruction = 16'h0000;

        // Async reset in the middle of a matmul
        for (int k = 0; k < 9; k++) begin
            a[k] = k + 1;
            b[k] = (k % 4 == 0) ? 1 : 0;
        end
        load_ab(a, b);
        send(16'h0001);
        bus.current_tensor_core_instruction = 16'h0000;
        repeat (9) tick();
        check("mid_mac_busy", bus.busy, 1);
        rst = 1'b1;
        #1;
        check("async_rst_busy", bus.busy, 0);
        check("async_rst_valid", bus.output_valid, 0);
        model_clear();
        tick();
        rst = 1'b0;
        tick();
        bread(0, 27);
        load_ab(a, b);
        operate(0);
        bread(18, 9);

        // RESET opcode during a burst read
        burst_hdr(0, 0, 10);
        bus.current_tensor_core_instruction = 16'h0000;
        for (int x = 0; x < 3; x++) begin
            check("pre_rst_valid", bus.output_valid, 1);
            check("pre_rst_data", bus.tensor_core_controller_output, m[x]);
            tick();
        end
        send(16'h0003);
        bus.current_tensor_core_instruction = 16'h0000;
        check("oprst_valid", bus.output_valid, 0);
        check("oprst_data", bus.tensor_core_controller_output, 0);
        check("oprst_busy", bus.busy, 0);
        model_clear();
        bread(0, 27);

        // Randomized operations, chained write-then-read and reads with wrap
        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < 9; k++) begin
                a[k] = s8(int'($urandom_range(255, 0)));
                b[k] = s8(int'($urandom_range(255, 0)));
            end
            load_ab(a, b);
            operate(int'($urandom_range(2, 0)));
            bread(18, 9);
            n = int'($urandom_range(8, 1));
            wq.delete();
            for (int x = 0; x < n; x++) wq.push_back(16'($urandom_range(65535, 0)));
            bwrite(int'($urandom_range(26, 0)), 1'b1);
            bread(int'($urandom_range(26, 0)), int'($urandom_range(27, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
